uart_tx_packer: RTL and testbench
=================================

# uart_tx_packer

Receive-side return path. Collects decoded data bits from the decoder output, packs them LSB-first into bytes, buffers them in a small FIFO, and serialises each byte as an 8N1 UART frame. The recovered stream can then be compared against the UART/sampling input on the transmit side. The block runs in the slow `clk` domain alongside the deinterleaver and decoder.

## Interface
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit period (≥2).
- `FIFO_DEPTH`, 4: byte FIFO entries (power of 2, ≥2).
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `valid_in` input 1: `bit_in` is valid this cycle; one bit consumed per high cycle.
- `bit_in` input 1: decoded data bit.
- `tx` output 1: UART serial line, idle high.
- `busy` output 1: high whenever the serialiser is not in IDLE.
- `overflow` output 1: sticky; a completed byte was dropped because the FIFO was full.
- `fifo_count` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `bits_pending` output 3: bits held in the packer (0..7).

## Operation
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, `bits_pending`=0. FSM goes to IDLE. FIFO pointers are 0. Packer and baud counter are cleared.
- **Packer:**
  - On `valid_in`=1, `bit_in` is written into byte bit position `bits_pending`, and `bits_pending` increments.
  - The first bit received becomes bit 0.
  - On the 8th bit, the assembled byte (including the current `bit_in`) is pushed to the FIFO in the same cycle, and `bits_pending` wraps to 0.
  - `valid_in`=0 cycles are gaps; the packer holds its state.
- **FIFO:**
  - Circular buffer with write/read pointers modulo FIFO_DEPTH.
  - A push is accepted if `fifo_count` < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, pointers are unchanged, and `overflow` is set and held until reset.
  - Simultaneous accepted push and pop leave `fifo_count` unchanged.
  - A pop on empty never occurs.
- **Serialiser FSM** (states IDLE, START, DATA, STOP). A baud counter counts 0..CLKS_PER_BIT-1. A bit index counts 0..7.
  - IDLE: `tx`=1. If `fifo_count`>0: pop head into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the last stop cycle:
    - if `fifo_count`>0: pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- `tx` and `busy` are registered outputs driven from the FSM state and shift register.
- **Reset mid-operation:** any in-flight frame is aborted and `tx` returns to 1 after the reset edge. The partial byte and all FIFO contents are discarded.

## Timing
- The edge at which the 8th `valid_in` is sampled is edge k. After edge k, `fifo_count`=1 (if the FIFO was empty).
- At edge k+1 (FSM in IDLE): pop. After k+1, `fifo_count`=0, `busy`=1, `tx`=0.
- Packer-to-line latency is therefore 2 cycles from the 8th bit.
- A frame is exactly 10×CLKS_PER_BIT cycles of `tx`: start, d0..d7, stop.
- Back-to-back frames have no idle cycle between them.
- `busy` falls on the edge after the last stop cycle, and only when the FIFO is empty.
- **Full + push + pop on the same edge:** the push is accepted and `fifo_count` stays at FIFO_DEPTH.
- **8th bit and reset on the same edge:** reset wins and nothing is pushed.

## Test plan
- **Reset state:** assert `reset` for 3 cycles, then idle. Required: `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0 throughout.
- **Single byte 0xA5:** CLKS_PER_BIT=4; feed bits 1,0,1,0,0,1,0,1 on consecutive cycles.
  - `tx` falls 2 cycles after the 8th bit.
  - `tx` then shows low ×4, then 1,0,1,0,0,1,0,1 each ×4, then high ×4 (40 cycles).
  - `busy` falls after the stop bit.
- **Back-to-back 0x00, 0xFF, 0x3C** with gapped `valid_in` (1 of every 2 cycles), CLKS_PER_BIT=4.
  - Three contiguous 40-cycle frames with no idle cycle between them.
  - Correct LSB-first data in each frame.
- **Overflow:** CLKS_PER_BIT=16, FIFO_DEPTH=4; `valid_in` high continuously for 48 bits (6 bytes).
  - Byte 1 is transmitting, bytes 2–5 are queued (`fifo_count`=4), and byte 6 is dropped.
  - `overflow`=1 and stays high.
  - Exactly 5 frames are emitted.
- **Reset mid-frame:** assert `reset` during DATA of byte 2, with byte 3 queued.
  - `tx`=1, `fifo_count`=0, and `bits_pending`=0 after the reset edge.
  - No further frames appear.
  - A new byte sent afterwards is framed correctly.
- **Partial byte hold:** feed 5 bits, idle 100 cycles, then feed 3 bits. Required: `bits_pending`=5 during the idle gap, and one frame carrying the combined byte.

Source files
------------

// File: rtl/uart_tx_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_tx_packer_if
// Brief   : Bit-stream input and UART/status output bundle of uart_tx_packer.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_tx_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             valid_in;
  logic             bit_in;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;
  logic [2:0]       bits_pending;

  modport master (
    output valid_in, bit_in,
    input  tx, busy, overflow, fifo_count, bits_pending
  );

  modport slave (
    input  valid_in, bit_in,
    output tx, busy, overflow, fifo_count, bits_pending
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_tx_packer
// Brief   : Packs decoded bits LSB-first into bytes, queues them, sends 8N1.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_packer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             clk,
  input logic             reset,
  uart_tx_packer_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Packer
  logic [7:0] pack_q, pack_d;
  logic [2:0] pend_q, pend_d;
  logic [7:0] byte_w;
  logic       push_w;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             accept_w;
  logic             pop_w;
  logic [7:0]       head_w;

  // Serialiser
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              baud_end_w;

  always_comb begin
    byte_w         = pack_q;
    byte_w[pend_q] = bus.bit_in;
    push_w         = bus.valid_in && (pend_q == 3'd7);
    pack_d         = pack_q;
    pend_d         = pend_q;
    if (bus.valid_in) begin
      pack_d = byte_w;
      pend_d = pend_q + 3'd1;
    end
  end

  // A full FIFO still takes a push when the serialiser frees a slot on the same edge.
  assign head_w   = mem_q[rptr_q];
  assign accept_w = push_w && ((count_q != C_DEPTH) || pop_w);

  always_comb begin
    count_d = count_q;
    case ({accept_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign baud_end_w = (baud_q == C_BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop_w   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_w   = 1'b1;
          sh_d    = head_w;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end_w) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end_w) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end_w) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop_w   = 1'b1;
            sh_d    = head_w;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the upcoming state so tx never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      mem_q[wptr_q] <= byte_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q     <= '0;
      pend_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      overflow_q <= overflow_q | (push_w & ~accept_w);
      if (accept_w) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_w) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = overflow_q;
  assign bus.fifo_count   = count_q;
  assign bus.bits_pending = pend_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_uart_tx_packer
// Brief   : Directed vector bench for uart_tx_packer (CLKS_PER_BIT 4 and 16).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_packer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  uart_tx_packer_if #(.FIFO_DEPTH(4)) b4 ();
  uart_tx_packer_if #(.FIFO_DEPTH(4)) b16 ();

  uart_tx_packer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  uart_tx_packer #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line monitor: slices each frame into 10 bit periods and records it.
  int         cyc;
  int         nfr [2];
  int         bhi [2];
  logic [9:0] fr  [2][64];
  logic       gl  [2][64];
  int         gp  [2][64];
  logic       m_act [2];
  int         m_pos [2];
  logic [9:0] m_cur [2];
  logic       m_gl  [2];
  int         m_last[2];
  int         m_gap [2];
  logic       m_t;
  logic       m_bz;
  int         m_c;
  int         m_b;

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      nfr[d] = 0; bhi[d] = 0; m_act[d] = 1'b0; m_pos[d] = 0;
      m_cur[d] = '0; m_gl[d] = 1'b0; m_last[d] = -1000; m_gap[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        m_t  = (d == 0) ? b4.tx : b16.tx;
        m_bz = (d == 0) ? b4.busy : b16.busy;
        m_c  = (d == 0) ? 4 : 16;
        if (m_bz === 1'b1) bhi[d]++;
        if (reset) begin
          m_act[d]  = 1'b0;
          m_last[d] = -1000;
        end else if (!m_act[d]) begin
          if (m_t === 1'b0) begin
            m_act[d] = 1'b1;
            m_pos[d] = 1;
            m_cur[d] = '0;
            m_gl[d]  = 1'b0;
            m_gap[d] = cyc - m_last[d] - 1;
          end
        end else begin
          m_b = m_pos[d] / m_c;
          if (m_pos[d] % m_c == 0) m_cur[d][m_b] = m_t;
          else if (m_cur[d][m_b] !== m_t) m_gl[d] = 1'b1;
          if (m_pos[d] == 10 * m_c - 1) begin
            if (nfr[d] < 64) begin
              fr[d][nfr[d]] = m_cur[d];
              gl[d][nfr[d]] = m_gl[d];
              gp[d][nfr[d]] = m_gap[d];
            end
            nfr[d]++;
            m_act[d]  = 1'b0;
            m_last[d] = cyc;
          end
          m_pos[d]++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic b);
    if (d == 0) begin
      b4.valid_in = v;  b4.bit_in = b;
    end else begin
      b16.valid_in = v; b16.bit_in = b;
    end
  endtask

  task automatic feed(input int d, input logic [7:0] data, input int first, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(d, 1'b1, data[first + i]);
      @(negedge clk);
      drive(d, 1'b0, 1'b0);
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  // Called on the first negedge after the 8th bit edge; FIFO and line must be empty/idle.
  task automatic expect_frame(input string nm, input logic [9:0] exp);
    int n;
    int base;
    base = nfr[0];
    chk({nm, "_cnt_k"}, 32'(b4.fifo_count), 32'd1);
    chk({nm, "_tx_k"}, 32'(b4.tx), 32'd1);
    @(negedge clk);
    chk({nm, "_cnt_k1"}, 32'(b4.fifo_count), 32'd0);
    chk({nm, "_busy_k1"}, 32'(b4.busy), 32'd1);
    chk({nm, "_tx_k1"}, 32'(b4.tx), 32'd0);
    n = 0;
    while (b4.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_len"}, 32'(n), 32'd40);
    chk({nm, "_nframes"}, 32'(nfr[0] - base), 32'd1);
    chk({nm, "_frame"}, 32'(fr[0][base & 63]), 32'(exp));
    chk({nm, "_glitch"}, 32'(gl[0][base & 63]), 32'd0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    int         gap;
    logic [9:0] frame;
  } vec_t;

  vec_t       vt [5];
  logic [7:0] ovb [6];
  logic [9:0] ovf_fr [5];
  int         base, bh, n, viol;

  initial begin
    vt[0] = '{"a5",   8'hA5, 0, 10'b1_10100101_0};
    vt[1] = '{"v00",  8'h00, 1, 10'b1_00000000_0};
    vt[2] = '{"vff",  8'hFF, 1, 10'b1_11111111_0};
    vt[3] = '{"v3c",  8'h3C, 2, 10'b1_00111100_0};
    vt[4] = '{"v01",  8'h01, 0, 10'b1_00000001_0};
    ovb[0] = 8'h11; ovb[1] = 8'h22; ovb[2] = 8'h33;
    ovb[3] = 8'h44; ovb[4] = 8'h55; ovb[5] = 8'h66;
    ovf_fr[0] = 10'b1_00010001_0; ovf_fr[1] = 10'b1_00100010_0;
    ovf_fr[2] = 10'b1_00110011_0; ovf_fr[3] = 10'b1_01000100_0;
    ovf_fr[4] = 10'b1_01010101_0;

    total = 0; bad = 0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);

    // Reset state, then idle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) reset = 1'b0;
      chk("rst_tx", 32'(b4.tx), 32'd1);
      chk("rst_busy", 32'(b4.busy), 32'd0);
      chk("rst_cnt", 32'(b4.fifo_count), 32'd0);
      chk("rst_ovf", 32'(b4.overflow), 32'd0);
      chk("rst_pend", 32'(b4.bits_pending), 32'd0);
      chk("rst16_tx", 32'(b16.tx), 32'd1);
    end

    // Single bytes from the vector table
    for (int v = 0; v < 5; v++) begin
      feed(0, vt[v].data, 0, 8, vt[v].gap);
      expect_frame(vt[v].name, vt[v].frame);
      repeat (3) @(negedge clk);
    end

    // Back-to-back 0x00, 0xFF, 0x3C with valid on every other cycle
    base = nfr[0];
    bh   = bhi[0];
    feed(0, 8'h00, 0, 8, 1); @(negedge clk);
    feed(0, 8'hFF, 0, 8, 1); @(negedge clk);
    feed(0, 8'h3C, 0, 8, 1);
    n = 0;
    while (b4.busy === 1'b1 && n < 600) begin n++; @(negedge clk); end
    chk("b2b_busy_end", 32'(b4.busy), 32'd0);
    chk("b2b_nframes", 32'(nfr[0] - base), 32'd3);
    chk("b2b_busy_cycles", 32'(bhi[0] - bh), 32'd120);
    chk("b2b_f0", 32'(fr[0][base]), 32'(10'b1_00000000_0));
    chk("b2b_f1", 32'(fr[0][base + 1]), 32'(10'b1_11111111_0));
    chk("b2b_f2", 32'(fr[0][base + 2]), 32'(10'b1_00111100_0));
    chk("b2b_gap1", 32'(gp[0][base + 1]), 32'd0);
    chk("b2b_gap2", 32'(gp[0][base + 2]), 32'd0);
    chk("b2b_glitch", 32'(gl[0][base] | gl[0][base + 1] | gl[0][base + 2]), 32'd0);

    // Overflow on the CLKS_PER_BIT=16 instance: 6 bytes, byte 6 dropped
    base = nfr[1];
    bh   = bhi[1];
    for (int i = 0; i < 48; i++) begin
      drive(1, 1'b1, ovb[i / 8][i % 8]);
      @(negedge clk);
      if (i == 4) chk("ovf_pend5", 32'(b16.bits_pending), 32'd5);
      if (i == 39) begin
        chk("ovf_cnt40", 32'(b16.fifo_count), 32'd4);
        chk("ovf_flag40", 32'(b16.overflow), 32'd0);
      end
      if (i == 47) begin
        chk("ovf_cnt48", 32'(b16.fifo_count), 32'd4);
        chk("ovf_flag48", 32'(b16.overflow), 32'd1);
      end
    end
    drive(1, 1'b0, 1'b0);
    n = 0;
    while (b16.busy === 1'b1 && n < 1500) begin n++; @(negedge clk); end
    chk("ovf_busy_end", 32'(b16.busy), 32'd0);
    chk("ovf_sticky", 32'(b16.overflow), 32'd1);
    chk("ovf_nframes", 32'(nfr[1] - base), 32'd5);
    chk("ovf_busy_cycles", 32'(bhi[1] - bh), 32'd800);
    for (int f = 0; f < 5; f++) begin
      chk($sformatf("ovf_frame%0d", f), 32'(fr[1][(base + f) & 63]), 32'(ovf_fr[f]));
      if (f > 0) chk($sformatf("ovf_gap%0d", f), 32'(gp[1][(base + f) & 63]), 32'd0);
    end

    // Partial byte held across a long gap: 0x9B split 5 + 3
    feed(0, 8'h9B, 0, 5, 0);
    chk("part_pend", 32'(b4.bits_pending), 32'd5);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b4.bits_pending !== 3'd5 || b4.tx !== 1'b1) viol++;
    end
    chk("part_hold", 32'(viol), 32'd0);
    feed(0, 8'h9B, 5, 3, 0);
    expect_frame("part", 10'b1_10011011_0);

    // Reset during DATA of byte 2 with byte 3 queued and 3 bits pending
    base = nfr[0];
    feed(0, 8'h12, 0, 8, 0);
    feed(0, 8'h34, 0, 8, 0);
    feed(0, 8'h56, 0, 8, 0);
    feed(0, 8'h07, 0, 3, 0);
    n = 0;
    while (nfr[0] == base && n < 200) begin n++; @(negedge clk); end
    chk("mid_f0", 32'(fr[0][base & 63]), 32'(10'b1_00010010_0));
    repeat (10) @(negedge clk);
    chk("mid_pre_cnt", 32'(b4.fifo_count), 32'd1);
    chk("mid_pre_pend", 32'(b4.bits_pending), 32'd3);
    chk("mid_pre_busy", 32'(b4.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_tx", 32'(b4.tx), 32'd1);
    chk("mid_cnt", 32'(b4.fifo_count), 32'd0);
    chk("mid_pend", 32'(b4.bits_pending), 32'd0);
    chk("mid_busy", 32'(b4.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = nfr[0];
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b4.tx !== 1'b1) viol++;
    end
    chk("mid_quiet", 32'(viol), 32'd0);
    chk("mid_noframes", 32'(nfr[0] - base), 32'd0);
    feed(0, 8'hC3, 0, 8, 0);
    expect_frame("mid_new", 10'b1_11000011_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
